modulo_r_down_timer: RTL and testbench

//   N-bit modulo-R down counter/timer: the count-down counterpart of the modulo-R up counter.

---
 rtl/modulo_r_down_timer.sv | 82 ++++++++
 tb/tb_modulo_r_down_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_r_down_timer.sv
// Modulo-R down counter/timer with periodic (wrap to R-1) or one-shot (stop at 0) operation.
// bout is the combinational borrow-out used to enable the next more significant stage.
module modulo_r_down_timer #(
   parameter int unsigned N = 4,
   parameter int unsigned R = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         start,
   input  logic         oneshot,
   output logic [N-1:0] qout,
   output logic         bout,
   output logic         busy,
   output logic         done,
   output logic         load_err
);

   localparam logic [N-1:0] RMAX = N'(R - 1);
   localparam logic [N-1:0] ONE  = N'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [N-1:0] r_qout;
   logic [N-1:0] w_qout_nxt;
   logic         r_load_err;
   logic         w_zero;
   logic         w_over;
   logic         w_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_qout     <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_qout     <= w_qout_nxt;
         r_load_err <= load & w_over;
      end
   end

   // Full-width compare: with R == 2**N, RMAX is all ones and w_over can never assert.
   always_comb begin
      w_zero      = (r_qout == '0);
      w_over      = (load_val > RMAX);
      w_tick      = (r_state == S_RUN) & enable;
      w_state_nxt = r_state;
      w_qout_nxt  = r_qout;
      if (load) begin
         w_state_nxt = S_IDLE;
         w_qout_nxt  = w_over ? RMAX : load_val;
      end else if (start && (r_state != S_RUN)) begin
         w_state_nxt = S_RUN;
      end else if (w_tick) begin
         if (!w_zero) begin
            w_qout_nxt = r_qout - ONE;
         end else if (oneshot) begin
            w_state_nxt = S_DONE;
         end else begin
            w_qout_nxt = RMAX;
         end
      end
   end

   always_comb begin
      qout     = r_qout;
      load_err = r_load_err;
      busy     = (r_state == S_RUN);
      done     = (r_state == S_DONE);
      bout     = (r_state == S_RUN) & enable & (r_qout == '0);
   end

endmodule

// File: tb/tb_modulo_r_down_timer.sv
// Scoreboard bench for modulo_r_down_timer: R=10 and R=16 instances share stimulus,
// plus a two-stage R=10 cascade checked as a two-digit decimal down counter.
module tb_modulo_r_down_timer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       oneshot;

   logic [3:0] q10, q16;
   logic       b10, bz10, dn10, er10;
   logic       b16, bz16, dn16, er16;

   logic       c_load, c_start, c_tick;
   logic [3:0] u_q, t_q;
   logic       u_b, u_bz, u_dn, u_er;
   logic       t_b, t_bz, t_dn, t_er;

   int unsigned checks;
   int unsigned failures;

   typedef struct packed {
      logic [3:0] q;
      logic       b;
      logic       bz;
      logic       dn;
      logic       er;
   } obs_t;

   typedef struct {
      obs_t a;
      obs_t b;
   } exp_t;

   typedef struct {
      int q;
      int st;
      bit err;
   } mdl_t;

   exp_t sb[$];
   int   csb[$];

   mdl_t m10, m16;
   int   cval;
   bit   crun;

   modulo_r_down_timer #(.N(4), .R(10)) dut10 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .load_val(load_val),
      .start(start), .oneshot(oneshot), .qout(q10), .bout(b10), .busy(bz10),
      .done(dn10), .load_err(er10)
   );

   modulo_r_down_timer #(.N(4), .R(16)) dut16 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .load_val(load_val),
      .start(start), .oneshot(oneshot), .qout(q16), .bout(b16), .busy(bz16),
      .done(dn16), .load_err(er16)
   );

   modulo_r_down_timer #(.N(4), .R(10)) u_units (
      .clk(clk), .reset(reset), .enable(c_tick), .load(c_load), .load_val(4'd0),
      .start(c_start), .oneshot(1'b0), .qout(u_q), .bout(u_b), .busy(u_bz),
      .done(u_dn), .load_err(u_er)
   );

   modulo_r_down_timer #(.N(4), .R(10)) u_tens (
      .clk(clk), .reset(reset), .enable(u_b), .load(c_load), .load_val(4'd0),
      .start(c_start), .oneshot(1'b0), .qout(t_q), .bout(t_b), .busy(t_bz),
      .done(t_dn), .load_err(t_er)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // States: 0 idle, 1 counting, 2 finished.
   function automatic mdl_t mdl_step(mdl_t m, int r, bit rst, bit ld, int lv,
                                     bit st, bit en, bit os);
      mdl_t n;
      n = m;
      if (rst) begin
         n.q = 0; n.st = 0; n.err = 1'b0;
      end else if (ld) begin
         n.q   = (lv > r - 1) ? r - 1 : lv;
         n.err = (lv > r - 1);
         n.st  = 0;
      end else begin
         n.err = 1'b0;
         if (st && m.st != 1) begin
            n.st = 1;
         end else if (m.st == 1 && en) begin
            if (m.q > 0)  n.q = m.q - 1;
            else if (os)  n.st = 2;
            else          n.q = r - 1;
         end
      end
      return n;
   endfunction

   function automatic obs_t mdl_obs(mdl_t m, bit en);
      obs_t o;
      o.q  = 4'(m.q);
      o.bz = (m.st == 1);
      o.dn = (m.st == 2);
      o.b  = (m.st == 1) && en && (m.q == 0);
      o.er = m.err;
      return o;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst, input bit ld, input int lv,
                        input bit st, input bit en, input bit os);
      exp_t e;
      reset    = rst;
      load     = ld;
      load_val = 4'(lv);
      start    = st;
      enable   = en;
      oneshot  = os;
      e.a = mdl_obs(m10, en);
      e.b = mdl_obs(m16, en);
      sb.push_back(e);
      @(posedge clk);
      m10 = mdl_step(m10, 10, rst, ld, lv, st, en, os);
      m16 = mdl_step(m16, 16, rst, ld, lv, st, en, os);
      #1;
   endtask

   task automatic ccycle(input bit ld, input bit st, input bit tick);
      c_load  = ld;
      c_start = st;
      c_tick  = tick;
      csb.push_back(cval);
      @(posedge clk);
      if (ld)        begin cval = 0; crun = 1'b0; end
      else if (st)   crun = 1'b1;
      else if (crun && tick) cval = (cval + 99) % 100;
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("r10.qout",     int'(q10),  int'(e.a.q));
         check("r10.bout",     int'(b10),  int'(e.a.b));
         check("r10.busy",     int'(bz10), int'(e.a.bz));
         check("r10.done",     int'(dn10), int'(e.a.dn));
         check("r10.load_err", int'(er10), int'(e.a.er));
         check("r16.qout",     int'(q16),  int'(e.b.q));
         check("r16.bout",     int'(b16),  int'(e.b.b));
         check("r16.busy",     int'(bz16), int'(e.b.bz));
         check("r16.done",     int'(dn16), int'(e.b.dn));
         check("r16.load_err", int'(er16), int'(e.b.er));
      end
      if (csb.size() > 0) begin
         int v;
         v = csb.pop_front();
         check("cascade.tens",  int'(t_q), v / 10);
         check("cascade.units", int'(u_q), v % 10);
      end
   end

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; enable = 1'b0; oneshot = 1'b0;
      c_load = 1'b0; c_start = 1'b0; c_tick = 1'b0;
      cval = 0; crun = 1'b0;
      @(posedge clk);
      m10 = '{q: 0, st: 0, err: 1'b0};
      m16 = m10;
      #1;
      cycle(0, 0, 0, 0, 0, 0);

      // periodic count through the wrap
      cycle(0, 1, 5, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1, 0);
      // one-shot stop and restart from DONE
      cycle(0, 1, 3, 0, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1, 1);
      // clamping and load_err pulse
      cycle(0, 1, 12, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 15, 0, 0, 0);
      cycle(0, 1, 7, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      // hold at zero with enable low, then wrap
      cycle(0, 1, 2, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      // load beats start; reset mid-run
      cycle(0, 1, 6, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
               int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 99) < 70), ($urandom_range(0, 3) == 0));
      end
      cycle(0, 0, 0, 0, 0, 0);

      // two-digit cascade: 00, 99, 98, ...
      ccycle(1, 0, 0);
      ccycle(0, 1, 0);
      for (int i = 0; i < 25; i++) ccycle(0, 0, 1);
      ccycle(0, 0, 0);

      for (int i = 0; i < 5 && (sb.size() > 0 || csb.size() > 0); i++) @(negedge clk);
      #1;
      if (sb.size() > 0 || csb.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d/%0d pending expected 0", sb.size(), csb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
